// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor table, oversample default.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // 1200..115200 baud at 16x oversampling from a 100 MHz clock
  localparam logic [12:0] BAUD_DIV_TABLE [0:7] = '{
    13'd5208, 13'd2604, 13'd1302, 13'd651,
    13'd326,  13'd163,  13'd109,  13'd54
  };

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RX line; flops reset to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic line,
  output logic line_sync
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) stages <= '1;
    else         stages <= {stages[SYNC_STAGES-2:0], line};
  end

  assign line_sync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, one stop bit, break detection.
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit after the data).
import uart_pkg::*;

module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       uart_en,
  input  logic [2:0] baud_rx_sel,
  input  logic       RX,
  output logic       rec_valid,
  output logic [7:0] rec_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  rx_state_e        state, state_nx;
  logic             rx_s, rx_prev;
  logic [12:0]      tick_cnt, div_q;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tick, mid, fall;
  logic             valid_set, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic             perr_set, par_bad;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .resetn    (resetn),
    .line      (RX),
    .line_sync (rx_s)
  );

  assign tick = (tick_cnt == div_q - 13'd1);
  assign mid  = tick && (os_cnt == OS_MID);
  assign fall = rx_prev && !rx_s;
  assign busy = (state != RX_IDLE);

  always_comb begin
    state_nx  = state;
    valid_set = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    if (!uart_en) begin
      state_nx = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:  if (fall) state_nx = RX_START;
        RX_START: if (mid) state_nx = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          if (mid && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = RX_PARITY;
`else
            state_nx = RX_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (mid) begin
            state_nx = RX_STOP;
            perr_set = (^shreg) != rx_s;
          end
        end
`endif
        RX_STOP: begin
          if (mid) begin
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              valid_set = !par_bad;
`else
              valid_set = 1'b1;
`endif
              state_nx  = RX_IDLE;
            end else begin
              ferr_set = 1'b1;
              state_nx = RX_BREAK;
            end
          end
        end
        RX_BREAK: if (rx_s) state_nx = RX_IDLE;
        default:  state_nx = RX_IDLE;
      endcase
    end
  end

  // Counters sit at zero throughout IDLE, which also provides the clear on entry to START.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= RX_IDLE;
      rx_prev  <= 1'b1;
      tick_cnt <= '0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      div_q    <= '0;
      shreg    <= '0;
    end else begin
      state   <= state_nx;
      rx_prev <= rx_s;
      if (state == RX_IDLE) begin
        tick_cnt <= '0;
        os_cnt   <= '0;
        bit_cnt  <= '0;
        if (state_nx == RX_START) div_q <= BAUD_DIV_TABLE[baud_rx_sel];
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 13'd1;
        if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        if (state == RX_DATA && mid) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rec_valid <= 1'b0;
      frame_err <= 1'b0;
      rec_data  <= '0;
    end else begin
      rec_valid <= valid_set;
      frame_err <= ferr_set;
      if (valid_set) rec_data <= shreg;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
    end else begin
      parity_err <= perr_set;
      if (state == RX_IDLE) par_bad <= 1'b0;
      else if (perr_set)    par_bad <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 115200 baud (sel 7, 864 clocks per bit); honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int BIT = 864;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 8211 + 864;
`else
  localparam int LAT = 8211;
`endif

  logic       clock = 1'b0;
  logic       resetn, uart_en, RX;
  logic [2:0] baud_rx_sel;
  logic       rec_valid, frame_err, parity_err, busy;
  logic [7:0] rec_data;

  uart_rx dut (
    .clock       (clock),
    .resetn      (resetn),
    .uart_en     (uart_en),
    .baud_rx_sel (baud_rx_sel),
    .RX          (RX),
    .rec_valid   (rec_valid),
    .rec_data    (rec_data),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_valid = 0, n_ferr = 0, n_perr = 0, n_overlap = 0, valid_cyc = 0;
  always @(negedge clock) begin
    if (rec_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (frame_err)  n_ferr = n_ferr + 1;
    if (parity_err) n_perr = n_perr + 1;
    if (rec_valid && (frame_err || parity_err)) n_overlap = n_overlap + 1;
  end

  int n_checks = 0, n_bad = 0;
  int t_start, v0, f0, p0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v0 = n_valid;
    f0 = n_ferr;
    p0 = n_perr;
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop,
                            input logic [2:0] mid_sel);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(data[i]);
      if (i == 3) baud_rx_sel = mid_sel;
    end
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    drive_bit(stop);
  endtask

  initial begin
    resetn = 1'b0;
    uart_en = 1'b1;
    RX = 1'b1;
    baud_rx_sel = 3'd7;
    repeat (5) @(negedge clock);
    check("rst_valid", rec_valid, 1'b0);
    check("rst_ferr",  frame_err, 1'b0);
    check("rst_perr",  parity_err, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_data",  rec_data, 8'h00);
    resetn = 1'b1;
    repeat (20) @(negedge clock);

    // good frame 5A
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 3'd7);
    drive_bit(1'b1);
    check("t1_valid", n_valid - v0, 1);
    check("t1_data",  rec_data, 8'h5A);
    check("t1_ferr",  n_ferr - f0, 0);
    check("t1_lat",   valid_cyc - t_start, LAT);
    check("t1_busy",  busy, 1'b0);

    // short low glitch at sel 3 is a false start
    snap();
    baud_rx_sel = 3'd3;
    RX = 1'b0;
    repeat (100) @(negedge clock);
    check("t2_busy_hi", busy, 1'b1);
    repeat (2900) @(negedge clock);
    RX = 1'b1;
    repeat (3000) @(negedge clock);
    check("t2_busy_lo", busy, 1'b0);
    check("t2_valid",   n_valid - v0, 0);
    check("t2_ferr",    n_ferr - f0, 0);
    baud_rx_sel = 3'd7;
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 3'd7);
    drive_bit(1'b1);
    check("t2b_valid", n_valid - v0, 1);
    check("t2b_data",  rec_data, 8'hA5);

    // bad stop bit followed by a held-low line
    snap();
    send_frame(8'hFF, 1'b0, 1'b0, 3'd7);
    check("t3_break_busy", busy, 1'b1);
    repeat (5000) @(negedge clock);
    check("t3_ferr",  n_ferr - f0, 1);
    check("t3_valid", n_valid - v0, 0);
    check("t3_data",  rec_data, 8'hA5);
    RX = 1'b1;
    repeat (20) @(negedge clock);
    check("t3_busy_lo", busy, 1'b0);
    check("t3_ferr2",   n_ferr - f0, 1);

    // disable after data bit 4 of 3C
    snap();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    uart_en = 1'b0;
    @(negedge clock);
    check("t4_busy", busy, 1'b0);
    RX = 1'b1;
    repeat (6 * BIT) @(negedge clock);
    check("t4_valid", n_valid - v0, 0);
    check("t4_ferr",  n_ferr - f0, 0);
    check("t4_perr",  n_perr - p0, 0);
    check("t4_data",  rec_data, 8'hA5);
    uart_en = 1'b1;
    repeat (20) @(negedge clock);

    // next frame 3C, baud select changed mid-frame
    snap();
    send_frame(8'h3C, 1'b0, 1'b1, 3'd0);
    drive_bit(1'b1);
    baud_rx_sel = 3'd7;
    check("t4b_valid", n_valid - v0, 1);
    check("t4b_data",  rec_data, 8'h3C);

    // reset mid-frame (byte FC); released while the line is high
    snap();
    drive_bit(1'b0);
    drive_bit(1'b0);
    RX = 1'b0;
    repeat (BIT / 2) @(negedge clock);
    resetn = 1'b0;
    repeat (4) @(negedge clock);
    check("t5_valid_rst", rec_valid, 1'b0);
    check("t5_ferr_rst",  frame_err, 1'b0);
    check("t5_perr_rst",  parity_err, 1'b0);
    check("t5_busy_rst",  busy, 1'b0);
    check("t5_data_rst",  rec_data, 8'h00);
    repeat (BIT / 2 - 4) @(negedge clock);
    RX = 1'b1;
    repeat (10) @(negedge clock);
    resetn = 1'b1;
    repeat (BIT - 10) @(negedge clock);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0);
`endif
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("t5_valid", n_valid - v0, 0);
    check("t5_busy",  busy, 1'b0);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, 3'd7);
    drive_bit(1'b1);
    check("p_perr",  n_perr - p0, 1);
    check("p_valid", n_valid - v0, 0);
    check("p_data",  rec_data, 8'h00);
    check("p_ferr",  n_ferr - f0, 0);
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 3'd7);
    drive_bit(1'b1);
    check("p_ok_valid", n_valid - v0, 1);
    check("p_ok_data",  rec_data, 8'h5A);
    check("p_ok_perr",  n_perr - p0, 0);
`endif

    check("overlap", n_overlap, 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the RX input synchronizer, minimum 2.
REQ-002 Parameter OVERSAMPLE, default 16: sample ticks per bit; the mid-bit sample is taken at tick OVERSAMPLE/2-1.
REQ-003 clock  input  1  system clock, 100 MHz nominal; all logic on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 uart_en  input  1  receiver enable; low forces the receiver idle.
REQ-006 baud_rx_sel  input  3  baud select index into the shared divisor table.
REQ-007 RX  input  1  serial line, asynchronous, idle high.
REQ-008 rec_valid  output  1  one-cycle pulse: a good frame was received.
REQ-009 rec_data  output  8  last good byte; held until the next good frame.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 RX shall pass through the SYNC_STAGES-flop synchronizer; all decisions use the synchronized value, and the synchronizer flops reset to 1.
REQ-014 A tick counter shall count 0..DIV-1 and then reload to 0, producing a one-cycle tick; DIV comes from the table entry for baud_rx_sel, latched when leaving IDLE.
REQ-015 Table for sel 0..7: 5208, 2604, 1302, 651, 326, 163, 109, 54 (1200..115200 baud at 16x oversampling); the counter is 13 bits.
REQ-016 States: IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
REQ-017 IDLE->START on a synchronized 1->0 transition while uart_en=1; the tick and sample counters clear on entry.
REQ-018 START: at the mid-bit sample, RX=0 -> DATA; RX=1 -> IDLE (false start) with no pulse.
REQ-019 DATA: 8 bits, LSB first, one sampled mid-bit every OVERSAMPLE ticks; after bit 7 -> PARITY or STOP.
REQ-020 STOP: mid-bit sample 1 -> rec_data updated and rec_valid pulsed on the next cycle, then IDLE; sample 0 -> frame_err pulsed, rec_data unchanged, then BREAK.
REQ-021 BREAK: wait until synchronized RX=1, then IDLE; a continuous low line shall not produce further frames.
REQ-022 Latency: rec_valid asserts exactly 1 cycle after the stop mid-bit tick.
REQ-023 uart_en deasserted in any state -> IDLE on the next edge; no pulses from the aborted frame; rec_data retained.
REQ-024 A baud_rx_sel change mid-frame shall not affect the current frame.
REQ-025 rec_valid and frame_err shall never be high in the same cycle; parity_err may coincide only with rec_valid=0.

Reset
REQ-026 While resetn=0: state IDLE, counters 0, rec_valid=0, frame_err=0, parity_err=0, busy=0, rec_data=8'h00.
REQ-027 Reset asserted mid-frame shall discard the frame; after release the receiver waits for a fresh falling edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: the PARITY state samples one even-parity bit after the data; on mismatch, parity_err is pulsed, rec_valid is suppressed, rec_data is unchanged, and the stop bit is still checked before IDLE.
REQ-029 Macro undefined: no PARITY state, frame is start + 8 data + stop, and parity_err is tied 0.

Structure
REQ-030 Package uart_pkg shall hold the state enum typedef, the baud divisor table constant, and the OVERSAMPLE default, shared with the transmitter.
REQ-031 One sub-module, uart_rx_sync (the parameterized synchronizer); the FSM and counters stay in uart_rx.

Verification
REQ-032 sel=7; frame 8'h5A with a good stop (bit period 864 cycles) -> rec_valid for 1 cycle, rec_data=8'h5A, frame_err=0.
REQ-033 sel=3; low glitch of 3000 cycles (below half of the 10416-cycle bit) -> no pulse, busy returns to 0, next frame 8'hA5 received correctly.
REQ-034 sel=7; 8'hFF sent with the stop bit low, then the line held low for 5000 cycles -> one frame_err pulse, rec_data unchanged, no further pulses until RX goes high.
REQ-035 uart_en dropped after data bit 4 -> busy=0 next cycle, no pulses; next frame 8'h3C received.
REQ-036 resetn pulsed low mid-frame -> all outputs at reset values; the remainder of the frame produces no rec_valid.
REQ-037 With UART_RX_PARITY_EN, 8'h5A sent with parity 1 (wrong) -> parity_err pulse, no rec_valid; parity 0 -> rec_valid with 8'h5A.
